// File: rtl/dec8421_pkg.sv
// Shared widths, state encoding and digit-field positions for the
// 5-digit BCD (8421) to 14-bit binary converter.
package dec8421_pkg;

    localparam int BIN_W  = 14;  // binary result width
    localparam int BCD_W  = 18;  // packed operand {d4[1:0], d3..d0[3:0]}
    localparam int DIGITS = 5;   // decimal digits in the operand
    localparam int ITER   = 14;  // shift iterations per conversion
    localparam int DIG_W  = 4;   // width of a full BCD digit
    localparam int CNT_W  = 4;   // iteration counter width (holds 0..ITER)

    // Digit-field slice positions inside the packed operand
    localparam int D0_LSB = 0;
    localparam int D1_LSB = 4;
    localparam int D2_LSB = 8;
    localparam int D3_LSB = 12;
    localparam int D4_LSB = 16;
    localparam int D4_W   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // True when any low digit exceeds 9 or the top digit exceeds 1
    function automatic logic digits_invalid(input logic [BCD_W-1:0] v);
        logic bad;
        bad = (v[D4_LSB +: D4_W] > 2'd1);
        bad = bad | (v[D0_LSB +: DIG_W] > 4'd9);
        bad = bad | (v[D1_LSB +: DIG_W] > 4'd9);
        bad = bad | (v[D2_LSB +: DIG_W] > 4'd9);
        bad = bad | (v[D3_LSB +: DIG_W] > 4'd9);
        return bad;
    endfunction

endpackage

// File: rtl/dec8421_digit_adj.sv
// Reverse double-dabble digit correction: after a right shift, a BCD digit
// that reads 8 or more carries half of a ten from its upper neighbour and
// must be reduced by 3 to stay a valid decimal digit.
module dec8421_digit_adj
    import dec8421_pkg::*;
(
    input  logic [DIG_W-1:0] din,
    output logic [DIG_W-1:0] dout
);

    // Subtract 3 from digits in the 8..15 range, pass others through
    always_comb begin
        dout = (din >= 4'd8) ? (din - 4'd3) : din;
    end

endmodule

// File: rtl/dec8421_to_bin.sv
// Sequential BCD (8421, 5 digits, 18-bit packed) to 14-bit binary converter
// using reverse double-dabble: 14 iterations of shift-right then subtract-3
// on every low digit that reads 8 or more.
// Handshake: start accepted while busy=0 (IDLE or DONE), busy for 15 cycles,
// then a one-cycle done pulse with bin/err valid and held until next done.
// Optional macro DEC8421_TO_BIN_CHECK_EN adds operand validity and overflow
// checking; without it err is constant 0 and bin is the raw accumulator.
module dec8421_to_bin
    import dec8421_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BCD_W-1:0] bcd,
    output logic             busy,
    output logic             done,
    output logic [BIN_W-1:0] bin,
    output logic             err
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [BCD_W-1:0] work;
    logic [BIN_W-1:0] acc;

    logic [BCD_W-1:0] work_sh;
    logic [BCD_W-1:0] work_nxt;
    logic [BIN_W-1:0] acc_nxt;
    logic             load;
    logic             res_err;

    assign busy = (state == SHIFT);
    assign done = (state == DONE);
    assign load = start && !busy;

    // One iteration: shift {work, acc} right by one, work bit 0 enters acc MSB
    always_comb begin
        {work_sh, acc_nxt} = {work, acc} >> 1;
    end

    // Correct the four full-width digits; the 2-bit top digit cannot reach 8
    for (genvar g = 0; g < DIGITS - 1; g++) begin : g_adj
        dec8421_digit_adj u_adj (
            .din  (work_sh[g*DIG_W +: DIG_W]),
            .dout (work_nxt[g*DIG_W +: DIG_W])
        );
    end
    assign work_nxt[D4_LSB +: D4_W] = work_sh[D4_LSB +: D4_W];

`ifdef DEC8421_TO_BIN_CHECK_EN
    logic inv_q;

    // Capture the digit-range verdict alongside the operand
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_q <= 1'b0;
        end else if (load) begin
            inv_q <= digits_invalid(bcd);
        end
    end

    // Any residue left in work after all iterations means value > 16383
    assign res_err = inv_q | (|work);
`else
    assign res_err = 1'b0;
`endif

    // FSM, iteration datapath and result registers
    // NOTE: state and datapath registers use non-blocking assignments so every
    // register samples the pre-edge values computed by the combinational step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            work  <= '0;
            acc   <= '0;
            bin   <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (load) begin
                        state <= SHIFT;
                        work  <= bcd;
                        acc   <= '0;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    if (cnt == CNT_W'(ITER)) begin
                        state <= DONE;
                        bin   <= res_err ? '0 : acc;
                        err   <= res_err;
                    end else begin
                        work <= work_nxt;
                        acc  <= acc_nxt;
                        cnt  <= cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dec8421_to_bin.sv
// Self-checking bench for dec8421_to_bin. The reference model decodes the
// decimal digits arithmetically and applies the range/overflow rules; it is
// built with or without DEC8421_TO_BIN_CHECK_EN to match the DUT.
module tb_dec8421_to_bin;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [17:0] bcd   = '0;
    logic        busy;
    logic        done;
    logic [13:0] bin;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dec8421_to_bin dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done),
        .bin   (bin),
        .err   (err)
    );

    // Decimal value of the operand plus the expected outputs
    function automatic void model(input logic [17:0] v, output logic [13:0] eb,
                                  output logic ee, output logic bin_known);
        int d0, d1, d2, d3, d4, val;
        logic inv;
        d0  = int'(v[3:0]);
        d1  = int'(v[7:4]);
        d2  = int'(v[11:8]);
        d3  = int'(v[15:12]);
        d4  = int'(v[17:16]);
        inv = (d0 > 9) || (d1 > 9) || (d2 > 9) || (d3 > 9) || (d4 > 1);
        val = d4 * 10000 + d3 * 1000 + d2 * 100 + d1 * 10 + d0;
`ifdef DEC8421_TO_BIN_CHECK_EN
        ee        = inv || (val > 16383);
        eb        = ee ? 14'd0 : 14'(val);
        bin_known = 1'b1;
`else
        ee        = 1'b0;
        eb        = 14'(val % 16384);
        bin_known = !inv;
`endif
    endfunction

    // Random operand: mostly legal digits, sometimes arbitrary bits
    function automatic logic [17:0] rand_bcd();
        logic [17:0] v;
        if ($urandom_range(0, 9) == 0) begin
            v = 18'($urandom);
        end else begin
            v = {2'($urandom_range(0, 1)), 4'($urandom_range(0, 9)),
                 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                 4'($urandom_range(0, 9))};
        end
        return v;
    endfunction

    // Issue one start pulse and wait (bounded) for done; optional noise
    // toggles start/bcd while busy
    task automatic conv(input logic [17:0] v, input logic noise,
                        output logic [13:0] rb, output logic re,
                        output int lat, output int busy_cnt);
        @(negedge clk);
        bcd   = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        bcd      = 18'($urandom);
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                bcd   = 18'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        rb    = bin;
        re    = err;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({busy, done, err, bin} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b bin=%0d expected all 0",
                     busy, done, err, bin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [17:0] ops [7];
        logic [13:0] rb, eb;
        logic re, ee, known;
        int lat, bc;
        ops = '{18'h00000, 18'h09999, 18'h16383, 18'h00100,
                18'h0A000, 18'h20000, 18'h16384};
        foreach (ops[i]) begin
            conv(ops[i], 1'b0, rb, re, lat, bc);
            model(ops[i], eb, ee, known);
            checks++;
            if (lat !== 15) begin
                errors++;
                $display("FAIL dir_latency[%h]: got %0d expected 15", ops[i], lat);
            end
            checks++;
            if (bc !== 15 || busy !== 1'b0) begin
                errors++;
                $display("FAIL dir_busy[%h]: got %0d busy cycles (busy at done=%b) expected 15 (0)",
                         ops[i], bc, busy);
            end
            checks++;
            if (re !== ee) begin
                errors++;
                $display("FAIL dir_err[%h]: got %b expected %b", ops[i], re, ee);
            end
            if (known) begin
                checks++;
                if (rb !== eb) begin
                    errors++;
                    $display("FAIL dir_bin[%h]: got %0d expected %0d", ops[i], rb, eb);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [17:0] v;
        logic [13:0] rb, eb;
        logic re, ee, known;
        int lat, bc;
        for (int n = 0; n < 150; n++) begin
            v = rand_bcd();
            conv(v, 1'b0, rb, re, lat, bc);
            model(v, eb, ee, known);
            checks++;
            if (re !== ee || (known && rb !== eb) || lat !== 15) begin
                errors++;
                $display("FAIL rand[%h]: got bin=%0d err=%b lat=%0d expected bin=%0d err=%b lat=15",
                         v, rb, re, lat, eb, ee);
            end
        end
    endtask

    task automatic test_busy_noise();
        logic [17:0] v;
        logic [13:0] rb, eb;
        logic re, ee, known;
        int lat, bc;
        for (int n = 0; n < 10; n++) begin
            v = rand_bcd();
            conv(v, 1'b1, rb, re, lat, bc);
            model(v, eb, ee, known);
            checks++;
            if (re !== ee || (known && rb !== eb) || lat !== 15 || bc !== 15) begin
                errors++;
                $display("FAIL noise[%h]: got bin=%0d err=%b lat=%0d busy=%0d expected bin=%0d err=%b lat=15 busy=15",
                         v, rb, re, lat, bc, eb, ee);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({busy, done} !== 2'b00) begin
                errors++;
                $display("FAIL noise_idle[%h]: got busy=%b done=%b expected 0 0", v, busy, done);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] v1, v2;
        logic [13:0] eb1, eb2;
        logic ee1, ee2, k1, k2;
        int lat1, lat2;
        v1 = 18'h12345;
        v2 = 18'h04321;
        model(v1, eb1, ee1, k1);
        model(v2, eb2, ee2, k2);
        @(negedge clk);
        bcd   = v1;
        start = 1'b1;
        @(posedge clk);
        #1;
        bcd  = v2;
        lat1 = 0;
        while (!done && lat1 < 40) begin
            @(posedge clk);
            #1;
            lat1++;
        end
        checks++;
        if (lat1 !== 15 || bin !== eb1 || err !== ee1) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d bin=%0d err=%b expected lat=15 bin=%0d err=%b",
                     lat1, bin, err, eb1, ee1);
        end
        lat2 = 0;
        do begin
            @(posedge clk);
            #1;
            lat2++;
        end while (!done && lat2 < 40);
        start = 1'b0;
        checks++;
        if (lat2 !== 16 || bin !== eb2 || err !== ee2) begin
            errors++;
            $display("FAIL b2b_second: got spacing=%0d bin=%0d err=%b expected spacing=16 bin=%0d err=%b",
                     lat2, bin, err, eb2, ee2);
        end
    endtask

    task automatic test_reset_mid();
        logic [13:0] rb;
        logic re;
        int lat, bc, dones;
        conv(18'h09999, 1'b0, rb, re, lat, bc);
        @(negedge clk);
        bcd   = 18'h16383;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, bin} !== 17'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got busy=%b done=%b err=%b bin=%0d expected all 0",
                     busy, done, err, bin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL mid_reset_no_done: got %0d done pulses expected 0", dones);
        end
        conv(18'h01234, 1'b0, rb, re, lat, bc);
        checks++;
        if (rb !== 14'd1234 || re !== 1'b0 || lat !== 15) begin
            errors++;
            $display("FAIL post_reset_conv: got bin=%0d err=%b lat=%0d expected bin=1234 err=0 lat=15",
                     rb, re, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_noise();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
